// File: rtl/score_bcd.sv
// score_bcd: turns line-clear events into points and adds them, one digit per cycle,
// into a saturating 4-digit BCD score. Define SCORE_HISCORE_EN for the high-score register.
module score_bcd #(
    parameter logic [3:0] P1 = 4'd1,
    parameter logic [3:0] P2 = 4'd3,
    parameter logic [3:0] P3 = 4'd5,
    parameter logic [3:0] P4 = 4'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       clr_valid,
    input  logic [2:0] clr_lines,
    output logic       busy,
    output logic       drop_err,
    output logic [3:0] score4,
    output logic [3:0] score3,
    output logic [3:0] score2,
    output logic [3:0] score1,
    output logic [3:0] hi4,
    output logic [3:0] hi3,
    output logic [3:0] hi2,
    output logic [3:0] hi1
);
    // state | meaning
    // IDLE  | no add in flight
    // ADDn  | adding into working digit n; ADD3 also commits the result
    typedef enum logic [2:0] {IDLE, ADD0, ADD1, ADD2, ADD3} state_t;

    state_t          state_q, state_d;
    logic [3:0][3:0] wdig_q, wdig_d;
    logic [3:0][3:0] score_q, score_d;
    logic            carry_q, carry_d;
    logic [3:0]      pts_q, pts_d;
    logic            pend_q, pend_d;
    logic [3:0]      pend_pts_q, pend_pts_d;
    logic            drop_q, drop_d;

    logic            ev_ok;
    logic [3:0]      ev_pts;
    logic [1:0]      idx;
    logic [3:0]      addend;
    logic [4:0]      t;
    logic [4:0]      t_adj;
    logic [3:0]      dig_sum;
    logic            c_sum;
    logic [3:0][3:0] result;

    always_comb begin
        ev_pts = 4'd0;
        case (clr_lines)
            3'd1:    ev_pts = P1;
            3'd2:    ev_pts = P2;
            3'd3:    ev_pts = P3;
            3'd4:    ev_pts = P4;
            default: ev_pts = 4'd0;
        endcase
        ev_ok = clr_valid && (clr_lines >= 3'd1) && (clr_lines <= 3'd4);
    end

    // Single shared digit adder; the state selects which working digit it serves.
    always_comb begin
        case (state_q)
            ADD1:    idx = 2'd1;
            ADD2:    idx = 2'd2;
            ADD3:    idx = 2'd3;
            default: idx = 2'd0;
        endcase
        addend  = (state_q == ADD0) ? pts_q : 4'd0;
        t       = {1'b0, wdig_q[idx]} + {1'b0, addend} + {4'd0, carry_q};
        t_adj   = t - 5'd10;
        c_sum   = (t > 5'd9);
        dig_sum = c_sum ? t_adj[3:0] : t[3:0];
        result    = wdig_q;
        result[3] = dig_sum;
        if (c_sum) result = {4{4'd9}};
    end

    always_comb begin
        state_d    = state_q;
        wdig_d     = wdig_q;
        score_d    = score_q;
        carry_d    = carry_q;
        pts_d      = pts_q;
        pend_d     = pend_q;
        pend_pts_d = pend_pts_q;
        drop_d     = drop_q;
        if (new_game) begin
            state_d    = IDLE;
            wdig_d     = '0;
            score_d    = '0;
            carry_d    = 1'b0;
            pend_d     = 1'b0;
            pend_pts_d = 4'd0;
            drop_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ev_ok) begin
                        wdig_d  = score_q;
                        pts_d   = ev_pts;
                        carry_d = 1'b0;
                        state_d = ADD0;
                    end
                end
                ADD0, ADD1, ADD2: begin
                    wdig_d[idx] = dig_sum;
                    carry_d     = c_sum;
                    state_d     = (state_q == ADD0) ? ADD1 : (state_q == ADD1) ? ADD2 : ADD3;
                    if (ev_ok) begin
                        if (pend_q) begin
                            drop_d = 1'b1;
                        end else begin
                            pend_d     = 1'b1;
                            pend_pts_d = ev_pts;
                        end
                    end
                end
                ADD3: begin
                    score_d = result;
                    wdig_d  = result;
                    carry_d = 1'b0;
                    // Pending pops on this edge, so a same-edge event refills it instead of dropping.
                    if (pend_q) begin
                        pts_d      = pend_pts_q;
                        state_d    = ADD0;
                        pend_d     = ev_ok;
                        pend_pts_d = ev_pts;
                    end else if (ev_ok) begin
                        pts_d   = ev_pts;
                        state_d = ADD0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wdig_q     <= '0;
            score_q    <= '0;
            carry_q    <= 1'b0;
            pts_q      <= 4'd0;
            pend_q     <= 1'b0;
            pend_pts_q <= 4'd0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wdig_q     <= wdig_d;
            score_q    <= score_d;
            carry_q    <= carry_d;
            pts_q      <= pts_d;
            pend_q     <= pend_d;
            pend_pts_q <= pend_pts_d;
            drop_q     <= drop_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign drop_err = drop_q;
    assign score4   = score_q[3];
    assign score3   = score_q[2];
    assign score2   = score_q[1];
    assign score1   = score_q[0];

`ifdef SCORE_HISCORE_EN
    // Digits are BCD, so an unsigned compare of the packed value orders by MSD first.
    logic [3:0][3:0] hi_q, hi_d;

    always_comb begin
        hi_d = hi_q;
        if (new_game && (score_q > hi_q)) hi_d = score_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hi_q <= '0;
        else     hi_q <= hi_d;
    end

    assign hi4 = hi_q[3];
    assign hi3 = hi_q[2];
    assign hi2 = hi_q[1];
    assign hi1 = hi_q[0];
`else
    assign hi4 = 4'd0;
    assign hi3 = 4'd0;
    assign hi2 = 4'd0;
    assign hi1 = 4'd0;
`endif

endmodule

// File: tb/tb_score_bcd.sv
// Scoreboard bench for score_bcd: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_score_bcd;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       new_game = 1'b0;
    logic       clr_valid = 1'b0;
    logic [2:0] clr_lines = 3'd0;
    logic       busy, drop_err;
    logic [3:0] score4, score3, score2, score1;
    logic [3:0] hi4, hi3, hi2, hi1;

    score_bcd dut (
        .clk(clk), .rst(rst), .new_game(new_game), .clr_valid(clr_valid),
        .clr_lines(clr_lines), .busy(busy), .drop_err(drop_err),
        .score4(score4), .score3(score3), .score2(score2), .score1(score1),
        .hi4(hi4), .hi3(hi3), .hi2(hi2), .hi1(hi1)
    );

    always #20 clk = ~clk;

    typedef struct {
        int          cyc;
        int          tag;
        logic [15:0] score;
        logic        busy;
        logic        drop;
        logic [15:0] hi;
    } exp_t;

    exp_t q[$];
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int ecyc = 0;
    int tag = 0;
    int m_hi = 0;
    int e = 0;

    always @(posedge clk) cyc++;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [15:0] hi_exp(input int v);
`ifdef SCORE_HISCORE_EN
        return to_bcd(v);
`else
        return (v < 0) ? 16'hffff : 16'h0000;
`endif
    endfunction

    task automatic check(input int tg, input string nm, input logic [15:0] got, input logic [15:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL chk%0d %s at cycle %0d: got %h, expected %h", tg, nm, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t x;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            x = q.pop_front();
            if (x.cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL chk%0d missed: due cycle %0d, now %0d", x.tag, x.cyc, cyc);
            end else begin
                check(x.tag, "score", {score4, score3, score2, score1}, x.score);
                check(x.tag, "busy", {15'd0, busy}, {15'd0, x.busy});
                check(x.tag, "drop_err", {15'd0, drop_err}, {15'd0, x.drop});
                check(x.tag, "hi", {hi4, hi3, hi2, hi1}, x.hi);
            end
        end
    end

    task automatic push(input int c, input int sc, input logic b, input logic d);
        exp_t x;
        tag++;
        x.cyc   = c;
        x.tag   = tag;
        x.score = to_bcd(sc);
        x.busy  = b;
        x.drop  = d;
        x.hi    = hi_exp(m_hi);
        q.push_back(x);
    endtask

    // Inputs set here are sampled on the next posedge; ecyc is the negedge right after it.
    task automatic drive(input logic v, input logic [2:0] l, input logic ng);
        @(negedge clk);
        clr_valid = v;
        clr_lines = l;
        new_game  = ng;
        ecyc      = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 3'd0, 1'b0);
    endtask

    task automatic add_ev(input logic [2:0] l);
        drive(1'b1, l, 1'b0);
        idle(3);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // reset state
        drive(1'b0, 3'd0, 1'b0);
        push(ecyc, 0, 1'b0, 1'b0);
        idle(2);

        // 4 lines from zero: busy 4 cycles, 0000 held until the jump to 0008
        drive(1'b1, 3'd4, 1'b0);
        e = ecyc;
        for (int k = 0; k < 4; k++) push(e + k, 0, 1'b1, 1'b0);
        push(e + 4, 8, 1'b0, 1'b0);
        idle(6);

        // out-of-range line counts are ignored
        drive(1'b1, 3'd0, 1'b0);
        push(ecyc + 1, 8, 1'b0, 1'b0);
        drive(1'b1, 3'd6, 1'b0);
        push(ecyc, 8, 1'b0, 1'b0);
        push(ecyc + 3, 8, 1'b0, 1'b0);
        idle(5);

        // new_game: high score takes 0008
        drive(1'b0, 3'd0, 1'b1);
        m_hi = 8;
        push(ecyc, 0, 1'b0, 1'b0);

        // lines 1,2,3 back to back: second pends, third drops
        drive(1'b1, 3'd1, 1'b0);
        e = ecyc;
        push(e, 0, 1'b1, 1'b0);
        drive(1'b1, 3'd2, 1'b0);
        push(e + 1, 0, 1'b1, 1'b0);
        drive(1'b1, 3'd3, 1'b0);
        push(e + 2, 0, 1'b1, 1'b1);
        drive(1'b0, 3'd0, 1'b0);
        push(e + 3, 0, 1'b1, 1'b1);
        push(e + 4, 1, 1'b1, 1'b1);
        push(e + 7, 1, 1'b1, 1'b1);
        push(e + 8, 4, 1'b0, 1'b1);
        idle(8);

        // new_game with score 0004 below high 0008: high unchanged, drop cleared
        drive(1'b0, 3'd0, 1'b1);
        push(ecyc, 0, 1'b0, 1'b0);

        // build 0120, then new_game in ADD2 with pending full
        for (int k = 0; k < 15; k++) add_ev(3'd4);
        idle(2);
        push(ecyc, 120, 1'b0, 1'b0);
        drive(1'b1, 3'd4, 1'b0);
        e = ecyc;
        push(e + 2, 120, 1'b1, 1'b0);
        drive(1'b1, 3'd1, 1'b0);
        drive(1'b0, 3'd0, 1'b0);
        drive(1'b0, 3'd0, 1'b1);
        m_hi = 120;
        push(e + 3, 0, 1'b0, 1'b0);
        push(e + 5, 0, 1'b0, 1'b0);
        push(e + 8, 0, 1'b0, 1'b0);
        idle(8);

        // build 0998, then +5 ripples to 1003 atomically
        for (int k = 0; k < 124; k++) add_ev(3'd4);
        add_ev(3'd3);
        add_ev(3'd1);
        idle(2);
        push(ecyc, 998, 1'b0, 1'b0);
        drive(1'b1, 3'd3, 1'b0);
        e = ecyc;
        for (int k = 0; k < 4; k++) push(e + k, 998, 1'b1, 1'b0);
        push(e + 4, 1003, 1'b0, 1'b0);
        idle(6);

        // build 9995, then saturate at 9999 and stay there
        for (int k = 0; k < 1124; k++) add_ev(3'd4);
        idle(2);
        push(ecyc, 9995, 1'b0, 1'b0);
        drive(1'b1, 3'd4, 1'b0);
        e = ecyc;
        push(e + 3, 9995, 1'b1, 1'b0);
        push(e + 4, 9999, 1'b0, 1'b0);
        idle(5);
        drive(1'b1, 3'd1, 1'b0);
        e = ecyc;
        push(e, 9999, 1'b1, 1'b0);
        push(e + 4, 9999, 1'b0, 1'b0);
        idle(6);

        // new_game from 9999 above high 0120
        drive(1'b0, 3'd0, 1'b1);
        m_hi = 9999;
        push(ecyc, 0, 1'b0, 1'b0);
        idle(3);

        for (int k = 0; k < 50 && q.size() > 0; k++) @(negedge clk);
        while (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL chk%0d timeout: due cycle %0d never checked", q[0].tag, q[0].cyc);
            void'(q.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
